// File: rtl/fifo_read_stream.sv
// Purpose: read-side drain of the async FIFO; turns registered-port reads into a FWFT valid/ready stream.
// Latency: read_out in cycle N -> word captured end of N+1 -> m_valid_out with that word in N+2.
// Backpressure: 3-entry prefetch buffer; reads are issued only while buffered + in-flight words < 3.
module fifo_read_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             empty_in,
    output logic             read_out,
    input  logic [WIDTH-1:0] data_read_in,
    output logic             m_valid_out,
    output logic [WIDTH-1:0] m_data_out,
    input  logic             m_ready_in,
    output logic [1:0]       count_out
);

    typedef logic [1:0] ptr_t;

    // Pointers wrap 0 -> 1 -> 2 -> 0.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    logic [WIDTH-1:0] mem_q [3];
    ptr_t             head_q;
    ptr_t             tail_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             pending_q;
    logic [2:0]       credit_used;
    logic             push;
    logic             pop;

    // Slots already spoken for: words held plus the word still on its way from the FIFO.
    assign credit_used = {1'b0, count_q} + {2'b0, pending_q};

    // Issue depends on registered state and empty_in only, never on m_ready_in,
    // so the consumer's ready never reaches the FIFO read strobe combinationally.
    assign read_out = !rst_in && !empty_in && (credit_used < 3'd3);

    // The word read last cycle is on data_read_in now and is always kept,
    // even if empty_in has risen since the read was issued.
    assign push = pending_q;
    assign pop  = m_valid_out && m_ready_in;

    assign m_valid_out = (count_q != 2'd0);
    assign m_data_out  = mem_q[head_q];
    assign count_out   = count_q;

    // Occupancy: simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Track the outstanding FIFO read (registered read port has one cycle of latency).
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= read_out;
        end
    end

    // Ring pointers and occupancy.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q  <= 2'd0;
            tail_q  <= 2'd0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                tail_q <= ptr_inc(tail_q);
            end
            if (pop) begin
                head_q <= ptr_inc(head_q);
            end
            count_q <= count_d;
        end
    end

    // Capture the arriving word at the tail. With count = 1 and push+pop together,
    // tail != head, so the word being popped is never the slot being written.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 3; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[tail_q] <= data_read_in;
        end
    end

endmodule

// File: tb/tb_fifo_read_stream.sv
module tb_fifo_read_stream;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       empty_in;
    logic       read_out;
    logic [7:0] data_read_in;
    logic       m_valid_out;
    logic [7:0] m_data_out;
    logic       m_ready_in;
    logic [1:0] count_out;

    fifo_read_stream #(.WIDTH(8)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .empty_in     (empty_in),
        .read_out     (read_out),
        .data_read_in (data_read_in),
        .m_valid_out  (m_valid_out),
        .m_data_out   (m_data_out),
        .m_ready_in   (m_ready_in),
        .count_out    (count_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Environment: words waiting in the FIFO, plus knobs.
    logic [7:0] src[$];
    logic       force_empty;
    logic       rdy_v;

    // Reference model: words held in the prefetch buffer and the word in flight.
    logic [7:0] mq[$];
    logic       m_infl;
    logic [7:0] m_infl_dat;

    // Logs per scenario.
    int         cyc;
    int         rd_cyc[$];
    int         acc_cyc[$];
    logic [7:0] acc_dat[$];
    logic       vld_log[64];
    logic [7:0] dat_log[64];
    logic [1:0] cnt_log[64];
    logic [7:0] sent[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clr_logs();
        rd_cyc.delete();
        acc_cyc.delete();
        acc_dat.delete();
        cyc = 0;
    endtask

    // One clock cycle, entered and left at a negedge.
    task automatic cycle();
        logic       e_rd, e_vld, d_rd;
        logic [7:0] w;
        empty_in   = force_empty || (src.size() == 0);
        m_ready_in = rdy_v;
        #1;
        e_rd  = !rst_in && !empty_in && ((mq.size() + int'(m_infl)) < 3);
        e_vld = (mq.size() != 0);
        chk("read_out", read_out, e_rd);
        chk("m_valid_out", m_valid_out, e_vld);
        chk("count_out", count_out, mq.size());
        if (e_vld) chk("m_data_out", m_data_out, mq[0]);
        d_rd = read_out;
        if (read_out) rd_cyc.push_back(cyc);
        if (m_valid_out && m_ready_in) begin
            acc_cyc.push_back(cyc);
            acc_dat.push_back(m_data_out);
        end
        if (cyc < 64) begin
            vld_log[cyc] = m_valid_out;
            dat_log[cyc] = m_data_out;
            cnt_log[cyc] = count_out;
        end
        @(posedge clk_in);
        if (rst_in) begin
            mq.delete();
            m_infl = 1'b0;
        end else begin
            if (e_vld && m_ready_in) void'(mq.pop_front());
            if (m_infl) mq.push_back(m_infl_dat);
            m_infl = e_rd;
        end
        @(negedge clk_in);
        if (d_rd && src.size() > 0) w = src.pop_front();
        else w = 8'($urandom);
        data_read_in = w;
        m_infl_dat   = w;
        cyc++;
    endtask

    // Asynchronous reset mid-cycle, held for some cycles, released at a negedge.
    task automatic do_reset(input int hold);
        #2 rst_in = 1'b1;
        #1;
        chk("async rst read_out", read_out, 1'b0);
        chk("async rst m_valid_out", m_valid_out, 1'b0);
        chk("async rst count_out", count_out, 2'd0);
        mq.delete();
        m_infl = 1'b0;
        src.delete();
        @(negedge clk_in);
        repeat (hold) cycle();
        rst_in = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic single_word_checks(input string tag);
        chk({tag, " read count"}, rd_cyc.size(), 1);
        chk({tag, " first read cycle"}, rd_cyc.size() > 0 ? rd_cyc[0] : -1, 0);
        chk({tag, " valid N+1"}, vld_log[1], 1'b0);
        chk({tag, " valid N+2"}, vld_log[2], 1'b1);
        chk({tag, " data N+2"}, dat_log[2], 8'hA5);
        chk({tag, " valid N+3"}, vld_log[3], 1'b0);
        chk({tag, " count N+3"}, cnt_log[3], 2'd0);
    endtask

    initial begin
        rst_in       = 1'b1;
        force_empty  = 1'b0;
        rdy_v        = 1'b1;
        data_read_in = 8'h00;
        empty_in     = 1'b1;
        m_ready_in   = 1'b1;
        m_infl       = 1'b0;
        m_infl_dat   = 8'h00;
        cyc          = 0;

        // Reset with a word waiting: nothing may be read while reset is held.
        src.push_back(8'hA5);
        @(negedge clk_in);
        run(2);
        chk("reset read_out", read_out, 1'b0);
        chk("reset count_out", count_out, 2'd0);
        rst_in = 1'b0;

        // Single word right after release.
        clr_logs();
        run(6);
        single_word_checks("single");

        // Burst of 16 with the consumer always ready.
        clr_logs();
        for (int i = 0; i < 16; i++) src.push_back(8'(i));
        run(22);
        chk("burst accepted", acc_dat.size(), 16);
        if (acc_dat.size() == 16) begin
            for (int i = 0; i < 16; i++) chk("burst data", acc_dat[i], 8'(i));
            chk("burst first accept", acc_cyc[0], 2);
            chk("burst gapless", acc_cyc[15] - acc_cyc[0], 15);
        end

        // Backpressure: buffer fills to 3, reads stop, head word holds.
        clr_logs();
        rdy_v = 1'b0;
        for (int i = 0; i < 8; i++) src.push_back(8'h30 + 8'(i));
        run(6);
        chk("bp count", cnt_log[5], 2'd3);
        chk("bp reads", rd_cyc.size(), 3);
        chk("bp head", dat_log[5], 8'h30);
        rdy_v = 1'b1;
        run(14);
        chk("bp accepted", acc_dat.size(), 8);
        if (acc_dat.size() == 8)
            for (int i = 0; i < 8; i++) chk("bp order", acc_dat[i], 8'h30 + 8'(i));

        // Empty rises the cycle after a read: in-flight word still delivered.
        clr_logs();
        for (int i = 0; i < 4; i++) src.push_back(8'h50 + 8'(i));
        run(1);
        force_empty = 1'b1;
        run(5);
        chk("empty reads", rd_cyc.size(), 1);
        chk("empty delivered", acc_dat.size(), 1);
        if (acc_dat.size() == 1) chk("empty word", acc_dat[0], 8'h50);
        force_empty = 1'b0;
        run(8);
        chk("empty resume total", acc_dat.size(), 4);
        if (acc_dat.size() == 4) chk("empty resume last", acc_dat[3], 8'h53);

        // Reset with count 2 and one read in flight.
        clr_logs();
        rdy_v = 1'b0;
        for (int i = 0; i < 8; i++) src.push_back(8'h70 + 8'(i));
        run(3);
        chk("pre-reset count", count_out, 2'd2);
        do_reset(2);
        clr_logs();
        rdy_v = 1'b1;
        src.push_back(8'hA5);
        run(6);
        single_word_checks("post-reset");

        // Random traffic, random backpressure, random empty glitches.
        clr_logs();
        sent.delete();
        for (int n = 0; n < 3000; n++) begin
            if (src.size() < 4 && $urandom_range(2, 0) == 0) begin
                logic [7:0] w;
                w = 8'($urandom);
                src.push_back(w);
                sent.push_back(w);
            end
            rdy_v       = ($urandom_range(3, 0) != 0);
            force_empty = ($urandom_range(7, 0) == 0);
            cycle();
        end
        rdy_v       = 1'b1;
        force_empty = 1'b0;
        run(20);
        chk("random accepted", acc_dat.size(), sent.size());
        if (acc_dat.size() == sent.size())
            for (int i = 0; i < sent.size(); i++) chk("random order", acc_dat[i], sent[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
